xx02_perf_counters: RTL and testbench
=====================================

Name: xx02_perf_counters

Overview:
- Performance-counter register block on the PERF port of the MM address decoder; occupies the 1K-word PERF window (iMM_ADDR 14'b0001_xxxx_xxxx_xx).
- Counts single-cycle event strobes from the PCIe application datapath in NUM_CNT saturating counters.
- Exposes control, status, ID and counter registers as 64-bit words, read/write through the decoder's PERF_* strobes.

Parameters:
- NUM_CNT, 8, number of event counters; legal range 1..16.
- CNT_W, 48, counter width in bits; legal range 1..63; read data is zero-extended to 64 bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- PERF_ADDR  in  14  word address; only [9:0] decoded, [13:10] ignored.
- PERF_WR_DATA  in  64  write data.
- PERF_WR_EN  in  1  single-cycle write strobe.
- PERF_RD_EN  in  1  single-cycle read strobe.
- PERF_RD_DATA  out  64  registered read data.
- PERF_RD_DATA_V  out  1  read-data valid pulse.
- iEVENT  in  NUM_CNT  per-counter increment strobes, synchronous to clk.

Behaviour:
- Reset: all counters 0, CTRL 0, STATUS 0, PERF_RD_DATA 0, PERF_RD_DATA_V 0.
- Register map (word offsets = PERF_ADDR[9:0]):
  - 0x000 CTRL, RW.
    - bit0 EN: counting enabled.
    - bit1 FRZ: freeze.
    - bit2 CLR_ALL: write-1 pulse, self-clearing, reads 0.
    - All other bits read 0.
  - 0x001 STATUS: bits [NUM_CNT-1:0] sticky saturation flags, write-1-to-clear; other bits read 0.
  - 0x002 ID, RO: 64'h5045_5246_0000_0000 | NUM_CNT.
  - 0x010+i, i<NUM_CNT: counter i, read returns {zeros, cnt_i}; any write clears counter i (data ignored).
  - Any other offset: read returns {32'hDEAD_BEEF, 22'b0, PERF_ADDR[9:0]}; write ignored.
- Read timing:
  - PERF_RD_EN sampled high in cycle T -> PERF_RD_DATA loaded and PERF_RD_DATA_V high in T+1, for exactly one cycle.
  - PERF_RD_DATA changes only on a read and holds until the next read. The decoder samples data one cycle after valid, so this hold is mandatory.
  - Back-to-back reads: one per cycle, no gaps required.
- Read value: the register state at the start of cycle T, i.e. before any increment, write or clear taking effect in T.
- Counting: counter i increments by 1 in a cycle when iEVENT[i]=1, EN=1, FRZ=0, and no clear applies to it.
- Saturation: at 2^CNT_W-1 the counter holds (no wrap) and STATUS[i] sets. An event at saturation keeps STATUS[i] set.
- CLR_ALL: zeroes all counters and STATUS in one cycle; EN/FRZ take the written values.
- Simultaneous events:
  - Clear (per-counter write or CLR_ALL) and event to the same counter: clear wins, result 0.
  - STATUS W1C and saturation set on the same bit in the same cycle: set wins.
  - PERF_WR_EN and PERF_RD_EN in the same cycle: write applied; read returns the pre-write value.
- FRZ=1: all counters hold and events are dropped (not queued). Registers remain readable and writable.
- Reset mid-read: PERF_RD_DATA_V drops immediately and asynchronously; no pending valid after reset release.

Decomposition:
- Package xx02_perf_pkg holds:
  - Offset constants: CTRL_OFS, STAT_OFS, ID_OFS, CNT_BASE.
  - CTRL bit indices.
  - ID_CONST.
  - Default-read pattern 32'hDEAD_BEEF.
- Sub-module xx02_perf_cnt: one CNT_W saturating counter with inc, clr and frz inputs, and cnt and sat outputs; generate-instantiated NUM_CNT times.
- Top level holds address decode, CTRL/STATUS registers and the read mux/register.

Test Plan:
- Reset, then read 0x002 -> PERF_RD_DATA=64'h5045_5246_0000_0008, PERF_RD_DATA_V high exactly one cycle, one cycle after PERF_RD_EN; data held stable 3 further cycles.
- Write CTRL=1, pulse iEVENT[3] 100 cycles, read 0x013 -> 64'd100; read 0x010 -> 0.
- Force counter 0 to 2^48-2 (CNT_W=48), two events on iEVENT[0] -> reads 0x0000_FFFF_FFFF_FFFF and STATUS=0x1; write STATUS=0x1 with no event -> STATUS reads 0.
- iEVENT[2] high continuously, write 0x012 in cycle T -> counter reads 0 right after the write, then 1 for an event in T+1; same-cycle read in T returns the pre-write count.
- CTRL=3 (FRZ) with events for 50 cycles -> counts unchanged; CTRL=5 -> all counters and STATUS 0, CTRL reads 1.
- Read 0x3FF -> 64'hDEAD_BEEF_0000_03FF; assert rst_n low in the cycle after PERF_RD_EN -> PERF_RD_DATA_V low immediately and all registers reset.

Source files
------------

// File: rtl/xx02_perf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xx02_perf_pkg
//  Description : Shared constants for the PERF counter register block:
//                register word offsets, CTRL bit positions, ID word and the
//                default read pattern returned for unmapped offsets.
//  Revision    : 1.0  initial release
// ============================================================================
package xx02_perf_pkg;

    // Word offsets within the PERF window (PERF_ADDR[9:0])
    localparam logic [9:0]  CTRL_OFS     = 10'h000;
    localparam logic [9:0]  STAT_OFS     = 10'h001;
    localparam logic [9:0]  ID_OFS       = 10'h002;
    localparam logic [9:0]  CNT_BASE     = 10'h010;

    // CTRL register bit positions
    localparam int          CTRL_EN_BIT  = 0;
    localparam int          CTRL_FRZ_BIT = 1;
    localparam int          CTRL_CLR_BIT = 2;

    // ID word; NUM_CNT is OR-ed into the low bits by the top level
    localparam logic [63:0] ID_CONST     = 64'h5045_5246_0000_0000;

    // Upper half of the value returned for unmapped offsets
    localparam logic [31:0] DFLT_RD_HI   = 32'hDEAD_BEEF;

    // Stored (non-pulse) CTRL fields
    typedef struct packed {
        logic frz;
        logic en;
    } ctrl_t;

    // Read value for an unmapped offset: pattern plus the offset itself
    function automatic logic [63:0] dflt_rd(input logic [9:0] ofs);
        return {DFLT_RD_HI, 22'b0, ofs};
    endfunction

endpackage
`default_nettype wire

// File: rtl/xx02_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : xx02_perf_cnt
//  Description : One saturating event counter.
//                clk, rst_n : clock, asynchronous active-low reset
//                inc        : increment request (already qualified by EN)
//                clr        : synchronous clear, wins over inc
//                frz        : hold value, inc is dropped
//                cnt        : current count
//                sat        : this cycle's accepted increment lands on, or is
//                             blocked at, the all-ones value
//  Revision    : 1.0  initial release
// ============================================================================
module xx02_perf_cnt #(
    parameter int CNT_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             frz,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inc_ok;
    logic             at_max;

    always_comb begin
        inc_ok = inc && !clr && !frz;
        at_max = (cnt_q == CNT_MAX);
        // Saturation is flagged both on the step into all-ones and on any
        // further event arriving while already pinned there.
        sat    = inc_ok && (at_max || (cnt_q == (CNT_MAX - CNT_W'(1))));
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc_ok && !at_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/xx02_perf_counters.sv
`default_nettype none
// ============================================================================
//  Module      : xx02_perf_counters
//  Description : Performance counter register block on the PERF decoder port.
//                NUM_CNT saturating event counters plus CTRL, STATUS and ID
//                registers, all exposed as 64-bit words.
//                clk, rst_n      : clock, asynchronous active-low reset
//                PERF_ADDR       : word address, only [9:0] decoded
//                PERF_WR_DATA/EN : write data and single-cycle strobe
//                PERF_RD_EN      : single-cycle read strobe
//                PERF_RD_DATA    : registered read data, held until next read
//                PERF_RD_DATA_V  : one-cycle valid, the cycle after PERF_RD_EN
//                iEVENT          : per-counter increment strobes
//  Revision    : 1.0  initial release
// ============================================================================
module xx02_perf_counters
    import xx02_perf_pkg::*;
#(
    parameter int NUM_CNT = 8,
    parameter int CNT_W   = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [13:0]        PERF_ADDR,
    input  logic [63:0]        PERF_WR_DATA,
    input  logic               PERF_WR_EN,
    input  logic               PERF_RD_EN,
    output logic [63:0]        PERF_RD_DATA,
    output logic               PERF_RD_DATA_V,
    input  logic [NUM_CNT-1:0] iEVENT
);

    logic [9:0]         ofs;
    logic               wr_ctrl;
    logic               wr_stat;
    logic               clr_all;
    logic [NUM_CNT-1:0] cnt_clr;
    logic [NUM_CNT-1:0] cnt_sat;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    ctrl_t              ctrl_q;
    ctrl_t              ctrl_d;
    logic [NUM_CNT-1:0] status_q;
    logic [NUM_CNT-1:0] status_d;
    logic [63:0]        rd_mux;
    logic [63:0]        rd_data_q;
    logic [63:0]        rd_data_d;
    logic               rd_v_q;
    logic               rd_v_d;

    // Address bits above the window and unused write-data bits are sunk here
    logic               unused_bits;
    assign unused_bits = &{1'b0, PERF_ADDR[13:10], PERF_WR_DATA};

    assign ofs = PERF_ADDR[9:0];

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    always_comb begin
        wr_ctrl = PERF_WR_EN && (ofs == CTRL_OFS);
        wr_stat = PERF_WR_EN && (ofs == STAT_OFS);
        clr_all = wr_ctrl && PERF_WR_DATA[CTRL_CLR_BIT];
        cnt_clr = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_clr[i] = clr_all || (PERF_WR_EN && (ofs == (CNT_BASE + 10'(i))));
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        xx02_perf_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (iEVENT[g] & ctrl_q.en),
            .clr   (cnt_clr[g]),
            .frz   (ctrl_q.frz),
            .cnt   (cnt_val[g]),
            .sat   (cnt_sat[g])
        );
    end

    // ------------------------------------------------------------------
    // CTRL / STATUS next state
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d.en  = PERF_WR_DATA[CTRL_EN_BIT];
            ctrl_d.frz = PERF_WR_DATA[CTRL_FRZ_BIT];
        end

        status_d = status_q;
        if (clr_all) begin
            status_d = '0;
        end else if (wr_stat) begin
            status_d = status_q & ~PERF_WR_DATA[NUM_CNT-1:0];
        end
        // Applied after the W1C so a same-cycle saturation keeps the bit set
        status_d = status_d | cnt_sat;
    end

    // ------------------------------------------------------------------
    // Read mux: uses current register state, so a same-cycle write or
    // increment is not visible to the read issued in that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = dflt_rd(ofs);
        if (ofs == CTRL_OFS) begin
            rd_mux               = '0;
            rd_mux[CTRL_EN_BIT]  = ctrl_q.en;
            rd_mux[CTRL_FRZ_BIT] = ctrl_q.frz;
        end else if (ofs == STAT_OFS) begin
            rd_mux                = '0;
            rd_mux[NUM_CNT-1:0]   = status_q;
        end else if (ofs == ID_OFS) begin
            rd_mux = ID_CONST | 64'(NUM_CNT);
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (ofs == (CNT_BASE + 10'(i))) begin
                rd_mux              = '0;
                rd_mux[CNT_W-1:0]   = cnt_val[i];
            end
        end

        rd_data_d = PERF_RD_EN ? rd_mux : rd_data_q;
        rd_v_d    = PERF_RD_EN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            status_q  <= '0;
            rd_data_q <= '0;
            rd_v_q    <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            rd_data_q <= rd_data_d;
            rd_v_q    <= rd_v_d;
        end
    end

    assign PERF_RD_DATA   = rd_data_q;
    assign PERF_RD_DATA_V = rd_v_q;

endmodule
`default_nettype wire

// File: tb/tb_xx02_perf_counters.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xx02_perf_counters
//  Description : Directed self-checking bench for xx02_perf_counters.
//                A 12-bit counter width keeps saturation reachable by
//                counting real events.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xx02_perf_counters;

    localparam int          TB_NUM_CNT = 8;
    localparam int          TB_CNT_W   = 12;
    localparam logic [63:0] C_ID       = 64'h5045_5246_0000_0008;
    localparam logic [63:0] C_SAT      = 64'h0000_0000_0000_0FFF;

    logic                  clk;
    logic                  rst_n;
    logic [13:0]           PERF_ADDR;
    logic [63:0]           PERF_WR_DATA;
    logic                  PERF_WR_EN;
    logic                  PERF_RD_EN;
    logic [63:0]           PERF_RD_DATA;
    logic                  PERF_RD_DATA_V;
    logic [TB_NUM_CNT-1:0] iEVENT;

    int n_vec  = 0;
    int n_miss = 0;

    xx02_perf_counters #(
        .NUM_CNT (TB_NUM_CNT),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PERF_ADDR      (PERF_ADDR),
        .PERF_WR_DATA   (PERF_WR_DATA),
        .PERF_WR_EN     (PERF_WR_EN),
        .PERF_RD_EN     (PERF_RD_EN),
        .PERF_RD_DATA   (PERF_RD_DATA),
        .PERF_RD_DATA_V (PERF_RD_DATA_V),
        .iEVENT         (iEVENT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic wr(input logic [13:0] a, input logic [63:0] d);
        @(negedge clk);
        PERF_ADDR    = a;
        PERF_WR_DATA = d;
        PERF_WR_EN   = 1'b1;
        @(negedge clk);
        PERF_WR_EN   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] a, input logic [63:0] exp);
        @(negedge clk);
        PERF_ADDR  = a;
        PERF_RD_EN = 1'b1;
        @(negedge clk);
        PERF_RD_EN = 1'b0;
        chk({tag, "_v"}, {63'b0, PERF_RD_DATA_V}, 64'd1);
        chk(tag, PERF_RD_DATA, exp);
    endtask

    task automatic ev(input logic [TB_NUM_CNT-1:0] m, input int n);
        @(negedge clk);
        iEVENT = m;
        repeat (n) @(negedge clk);
        iEVENT = '0;
    endtask

    initial begin
        rst_n        = 1'b0;
        PERF_ADDR    = '0;
        PERF_WR_DATA = '0;
        PERF_WR_EN   = 1'b0;
        PERF_RD_EN   = 1'b0;
        iEVENT       = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_data", PERF_RD_DATA, 64'd0);
        chk("rst_v", {63'b0, PERF_RD_DATA_V}, 64'd0);

        // ID read: one-cycle valid, data held afterwards
        PERF_ADDR  = 14'h002;
        PERF_RD_EN = 1'b1;
        @(negedge clk);
        PERF_RD_EN = 1'b0;
        chk("id_v", {63'b0, PERF_RD_DATA_V}, 64'd1);
        chk("id", PERF_RD_DATA, C_ID);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("id_v_low", {63'b0, PERF_RD_DATA_V}, 64'd0);
            chk("id_hold", PERF_RD_DATA, C_ID);
        end

        // Basic counting
        wr(14'h000, 64'd1);
        ev(8'h08, 100);
        rd_chk("cnt3_100", 14'h013, 64'd100);
        rd_chk("cnt0_0", 14'h010, 64'd0);

        // Saturation on counter 0
        ev(8'h01, 4094);
        rd_chk("cnt0_fffe", 14'h010, 64'hFFE);
        rd_chk("stat_pre", 14'h001, 64'd0);
        ev(8'h01, 2);
        rd_chk("cnt0_sat", 14'h010, C_SAT);
        rd_chk("stat_sat", 14'h001, 64'd1);
        // W1C together with an event at saturation: set wins
        @(negedge clk);
        PERF_ADDR    = 14'h001;
        PERF_WR_DATA = 64'd1;
        PERF_WR_EN   = 1'b1;
        iEVENT       = 8'h01;
        @(negedge clk);
        PERF_WR_EN   = 1'b0;
        iEVENT       = '0;
        rd_chk("stat_setwin", 14'h001, 64'd1);
        wr(14'h001, 64'd1);
        rd_chk("stat_w1c", 14'h001, 64'd0);
        rd_chk("cnt0_hold", 14'h010, C_SAT);

        // Clear beats event; same-cycle read returns pre-write count
        @(negedge clk);
        iEVENT = 8'h04;
        repeat (5) @(negedge clk);
        PERF_ADDR    = 14'h012;
        PERF_WR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
        PERF_WR_EN   = 1'b1;
        PERF_RD_EN   = 1'b1;
        @(negedge clk);
        PERF_WR_EN   = 1'b0;
        chk("cnt2_prewr", PERF_RD_DATA, 64'd5);
        @(negedge clk);
        iEVENT       = '0;
        chk("cnt2_clr", PERF_RD_DATA, 64'd0);
        @(negedge clk);
        PERF_RD_EN   = 1'b0;
        chk("cnt2_one", PERF_RD_DATA, 64'd1);

        // Freeze drops events
        wr(14'h000, 64'd3);
        ev(8'hFF, 50);
        rd_chk("ctrl_frz", 14'h000, 64'd3);
        rd_chk("frz_cnt3", 14'h013, 64'd100);
        rd_chk("frz_cnt2", 14'h012, 64'd1);
        rd_chk("frz_cnt0", 14'h010, C_SAT);
        rd_chk("frz_stat", 14'h001, 64'd0);

        // CLR_ALL: counters cleared, EN/FRZ take written values
        wr(14'h000, 64'd5);
        rd_chk("ctrl_after_clr", 14'h000, 64'd1);
        rd_chk("clr_cnt0", 14'h010, 64'd0);
        rd_chk("clr_cnt3", 14'h013, 64'd0);
        rd_chk("clr_stat", 14'h001, 64'd0);

        // Back-to-back reads, upper address bits ignored
        ev(8'h08, 3);
        @(negedge clk);
        PERF_ADDR  = 14'h002;
        PERF_RD_EN = 1'b1;
        @(negedge clk);
        PERF_ADDR  = 14'h3C13;
        chk("b2b_v0", {63'b0, PERF_RD_DATA_V}, 64'd1);
        chk("b2b_id", PERF_RD_DATA, C_ID);
        @(negedge clk);
        PERF_RD_EN = 1'b0;
        chk("b2b_v1", {63'b0, PERF_RD_DATA_V}, 64'd1);
        chk("b2b_cnt3", PERF_RD_DATA, 64'd3);

        // Unmapped offset
        rd_chk("dflt", 14'h3FFF, 64'hDEAD_BEEF_0000_03FF);

        // Reset in the cycle after a read strobe
        @(negedge clk);
        PERF_ADDR  = 14'h013;
        PERF_RD_EN = 1'b1;
        @(posedge clk);
        #1;
        PERF_RD_EN = 1'b0;
        chk("rr_v_pre", {63'b0, PERF_RD_DATA_V}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_v_async", {63'b0, PERF_RD_DATA_V}, 64'd0);
        chk("rr_data_async", PERF_RD_DATA, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_no_pending", {63'b0, PERF_RD_DATA_V}, 64'd0);
        rd_chk("rr_ctrl", 14'h000, 64'd0);
        rd_chk("rr_cnt3", 14'h013, 64'd0);
        rd_chk("rr_stat", 14'h001, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
